// File: rtl/branch_pred_ctrl.sv
// Branch predictor: a table of 2-bit saturating counters plus a queued read-modify-write update engine.
// Optional saturating mispredict counter is enabled by defining BP_MISPRED_CNT_EN.
module branch_pred_ctrl #(
    parameter int IDX_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_rvalid,
    output logic             lk_taken,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [IDX_W-1:0] res_idx,
    input  logic [1:0]       res_op,
    input  logic [3:0]       res_a,
    input  logic [3:0]       res_b,
    input  logic             res_pred,
    output logic             busy,
    output logic [7:0]       mispred_cnt
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {OP_BEQ = 2'b00, OP_BNE = 2'b01, OP_BLT = 2'b10, OP_BGE = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE} state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        op_e              op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic             pred;
    } res_t;

    logic [1:0]     ctr [ENTRIES];
    res_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    state_e         state;
    res_t           work;
    logic [1:0]     work_ctr;
    logic           work_mis;
    logic           calc_taken;

    function automatic logic eval_taken(input op_e op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        else       return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign res_ready  = !full;
    assign push       = res_valid && !full;
    assign pop        = (state == S_IDLE) && !empty;
    assign busy       = (state != S_IDLE) || !empty;
    assign calc_taken = eval_taken(work.op, work.a, work.b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: queue payload needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{res_idx, op_e'(res_op), res_a, res_b, res_pred};
    end

    // NOTE: the counter table is reset because predictions must start at strongly-not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b00;
        end else if (state == S_WRITE) begin
            ctr[work.idx] <= work_ctr;
        end
    end

    // Non-blocking read: a lookup in the WRITE cycle sees the pre-write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rvalid <= 1'b0;
            lk_taken  <= 1'b0;
        end else begin
            lk_rvalid <= lk_valid;
            if (lk_valid) lk_taken <= ctr[lk_idx][1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            work     <= '0;
            work_ctr <= 2'b00;
            work_mis <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        work  <= fifo_mem[rd_ptr[PTR_W-1:0]];
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    work_ctr <= sat_step(ctr[work.idx], calc_taken);
                    work_mis <= (calc_taken != work.pred);
                    state    <= S_WRITE;
                end
                S_WRITE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BP_MISPRED_CNT_EN
    logic [7:0] mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 8'h00;
        end else if (state == S_WRITE && work_mis && mis_q != 8'hFF) begin
            mis_q <= mis_q + 8'd1;
        end
    end

    assign mispred_cnt = mis_q;
`else
    // Mispredict flag has no consumer in this build.
    logic unused_mis;
    assign unused_mis  = work_mis;
    assign mispred_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed and random resolves checked against
// an arithmetic reference model of the counter table and mispredict count.
module tb_branch_pred_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       lk_valid;
    logic [3:0] lk_idx;
    logic       lk_rvalid;
    logic       lk_taken;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_idx;
    logic [1:0] res_op;
    logic [3:0] res_a;
    logic [3:0] res_b;
    logic       res_pred;
    logic       busy;
    logic [7:0] mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ctr[16];
    int m_mis;
    int stall_cycles;

`ifdef BP_MISPRED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    branch_pred_ctrl #(.IDX_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_rvalid(lk_rvalid), .lk_taken(lk_taken),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_op(res_op),
        .res_a(res_a), .res_b(res_b), .res_pred(res_pred),
        .busy(busy), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: evaluate the branch, step the counter and clamp it to [0,3].
    task automatic model_apply(input int idx, input int op, input int a, input int b, input int pred);
        bit t;
        case (op)
            0:       t = (a == b);
            1:       t = (a != b);
            2:       t = (a < b);
            default: t = (a >= b);
        endcase
        m_ctr[idx] = m_ctr[idx] + (t ? 1 : -1);
        if (m_ctr[idx] > 3) m_ctr[idx] = 3;
        if (m_ctr[idx] < 0) m_ctr[idx] = 0;
        if (int'(t) != pred && m_mis < 255) m_mis++;
    endtask

    function automatic int exp_mis();
        return CNT_EN ? m_mis : 0;
    endfunction

    task automatic push(input int idx, input int op, input int a, input int b, input int pred);
        int waited = 0;
        res_valid = 1'b1;
        res_idx   = 4'(idx);
        res_op    = 2'(op);
        res_a     = 4'(a);
        res_b     = 4'(b);
        res_pred  = 1'(pred);
        while (!res_ready && waited < 50) begin
            stall_cycles++;
            tick();
            waited++;
        end
        if (waited == 50) check("push_ready_timeout", res_ready, 1'b1);
        tick();
        res_valid = 1'b0;
        model_apply(idx, op, a, b, pred);
    endtask

    task automatic push_random(input int max_idx);
        push(int'($urandom_range(max_idx, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(1, 0)));
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        if (busy) check("drain_timeout", busy, 1'b0);
    endtask

    task automatic lookup(input int idx, output logic t);
        lk_valid = 1'b1;
        lk_idx   = 4'(idx);
        tick();
        lk_valid = 1'b0;
        check("lk_rvalid", lk_rvalid, 1'b1);
        t = lk_taken;
    endtask

    task automatic check_idx(input string tag, input int idx);
        logic t;
        lookup(idx, t);
        check($sformatf("%s_idx%0d", tag, idx), t, m_ctr[idx] >= 2);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 16; i++) check_idx(tag, i);
        check({tag, "_mispred"}, mispred_cnt, exp_mis());
    endtask

    initial begin
        logic t;
        rst_n = 1'b0; lk_valid = 1'b0; lk_idx = '0; res_valid = 1'b0;
        res_idx = '0; res_op = '0; res_a = '0; res_b = '0; res_pred = 1'b0;
        for (int i = 0; i < 16; i++) m_ctr[i] = 0;
        m_mis = 0;
        stall_cycles = 0;

        #2;
        check("rst_lk_rvalid", lk_rvalid, 1'b0);
        check("rst_lk_taken", lk_taken, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mispred", mispred_cnt, 8'h00);
        check("rst_res_ready", res_ready, 1'b1);
        #10 rst_n = 1'b1;
        tick();

        // Single lookup after reset, then idle cycle keeps lk_taken.
        lk_valid = 1'b1; lk_idx = 4'd3;
        tick();
        check("t1_rvalid", lk_rvalid, 1'b1);
        check("t1_taken", lk_taken, 1'b0);
        lk_valid = 1'b0;
        tick();
        check("t1_rvalid_low", lk_rvalid, 1'b0);

        // Two taken BEQs predicted not-taken: counter 00 -> 10.
        push(5, 0, 7, 7, 0);
        push(5, 0, 7, 7, 0);
        drain();
        check_idx("t2", 5);
        check("t2_mispred", mispred_cnt, exp_mis());
        lk_idx = 4'd0;
        tick();
        check("t2_hold_rvalid", lk_rvalid, 1'b0);
        check("t2_hold_taken", lk_taken, m_ctr[5] >= 2);

        // Floor saturation, then climb to the ceiling and step back once.
        for (int i = 0; i < 3; i++) push(2, 3, 1, 9, 0);
        drain();
        check_idx("t4_floor", 2);
        push(2, 2, 0, 15, 0);
        drain();
        check_idx("t4_floor_exact", 2);
        for (int i = 0; i < 3; i++) push(2, 2, 0, 15, 0);
        drain();
        check_idx("t4_ceil", 2);
        push(2, 3, 1, 9, 0);
        drain();
        check_idx("t4_ceil_exact", 2);
        push(2, 3, 1, 9, 0);
        drain();
        check_idx("t5_pre", 2);

        // Lookup during the WRITE cycle of 01->10 sees the old value.
        push(2, 2, 0, 15, 0);
        tick();
        tick();
        lk_valid = 1'b1; lk_idx = 4'd2;
        tick();
        check("t5_write_cycle", lk_taken, 1'b0);
        tick();
        check("t5_next_cycle", lk_taken, 1'b1);
        lk_valid = 1'b0;
        drain();

        // Back-to-back pushes onto few indices fill the queue and stall.
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) push_random(3);
        check("t3_stall_seen", stall_cycles != 0, 1'b1);
        drain();
        check_table("t3");

        // Random traffic with gaps.
        for (int i = 0; i < 60; i++) begin
            push_random(15);
            repeat ($urandom_range(2, 0)) tick();
        end
        drain();
        check_table("rand");

        // Long run of mispredicts to reach counter saturation.
        for (int i = 0; i < 260; i++) push(7, 0, 0, 1, 1);
        drain();
        check("sat_mispred", mispred_cnt, exp_mis());
        check_idx("sat", 7);

        // Reset mid-update with entries queued.
        for (int i = 0; i < 6; i++) push(i, 0, 3, 3, 0);
        tick();
        check("t6_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_res_ready", res_ready, 1'b1);
        check("t6_mispred", mispred_cnt, 8'h00);
        check("t6_lk_rvalid", lk_rvalid, 1'b0);
        check("t6_lk_taken", lk_taken, 1'b0);
        for (int i = 0; i < 16; i++) m_ctr[i] = 0;
        m_mis = 0;
        #3 rst_n = 1'b1;
        repeat (4) tick();
        check("t6_idle_after", busy, 1'b0);
        check_table("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
